// File: rtl/da_shift_accumulator.sv
// Bit-serial shift-accumulator for a distributed-arithmetic FIR.
// Consumes N LUT partial sums, one per bit slice, LSB first, and emits the exact two's-complement result.
module da_shift_accumulator #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 20
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic signed [W-1:0]   psum,
    output logic                  bit_en,
    output logic                  busy,
    output logic signed [W+N-1:0] y,
    output logic                  out_valid
);

    localparam int unsigned KW = $clog2(N);
    localparam int unsigned AW = W + N;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [KW-1:0]        k, k_nxt;
    logic signed [AW-1:0] acc, acc_nxt;
    logic signed [AW-1:0] y_nxt;
    logic                 valid_nxt;
    logic signed [AW-1:0] psum_ext;
    logic signed [AW-1:0] term;
    logic signed [AW-1:0] sum;

    // Weighted slice term; the MSB slice carries negative weight.
    always_comb begin
        psum_ext = {{N{psum[W-1]}}, psum};
        term     = psum_ext <<< k;
        sum      = (k == K_LAST) ? (acc - term) : (acc + term);
    end

    // Next-state and datapath control.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        acc_nxt   = acc;
        y_nxt     = y;
        valid_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    k_nxt     = '0;
                    acc_nxt   = '0;
                end
            end
            RUN: begin
                acc_nxt = sum;
                if (k == K_LAST) begin
                    y_nxt     = sum;
                    valid_nxt = 1'b1;
                    k_nxt     = '0;
                    if (start) begin
                        state_nxt = RUN;
                        acc_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    k_nxt = k + KW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                k_nxt     = '0;
                acc_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            k         <= '0;
            acc       <= '0;
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            acc       <= acc_nxt;
            y         <= y_nxt;
            out_valid <= valid_nxt;
        end
    end

    // Shift enable and busy are pure state decodes.
    assign bit_en = (state == RUN);
    assign busy   = (state == RUN);

endmodule

// File: doc/da_shift_accumulator.md
# da_shift_accumulator

Serial-to-parallel shift-accumulator for the distributed-arithmetic FIR datapath. It sits downstream of the parallel-load, LSB-first right-shift registers and the partial-sum LUT they address. For each input sample it sequences the shift registers through N bit cycles and accumulates the LUT partial sums with binary weighting, treating the MSB term as the two's-complement sign bit. It then presents the exact filter output as a parallel word with a one-cycle valid strobe.

## Interface
- N, 16, input sample width in bits; equals the number of bit cycles per sample (N >= 2)
- W, 20, signed partial-sum width from the LUT (W >= 2)
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset, synchronous, active-low
- start  in  1  begin a new sample; the same signal drives `load` of the upstream shift registers
- psum  in  W  signed LUT partial sum for the current bit slice; combinational from the shift-register outputs
- bit_en  out  1  shift enable to the upstream shift registers; asserted in every RUN cycle
- busy  out  1  high while in RUN
- y  out  W+N  signed result of the last completed sample; held until the next completion
- out_valid  out  1  one-cycle pulse when y updates

## Operation
- States: IDLE and RUN.
- Registers: bit counter k, range 0..N-1, width ceil(log2 N); accumulator; y; out_valid.
- Result definition: y = sum over k=0..N-2 of psum_k·2^k − psum_{N-1}·2^{N-1}. psum is sign-extended to W+N bits.
  - The result is exact: no saturation and no rounding.
  - The internal accumulation order is free, provided y is bit-exact.
- IDLE:
  - With start=1: clear the accumulator, set k=0, move to RUN.
  - With start=0: remain in IDLE.
- RUN, each cycle:
  - bit_en=1 and busy=1.
  - psum is taken as bit slice k. For k<N-1 it is added with weight 2^k. For k=N-1 it is subtracted with weight 2^{N-1}.
  - When k<N-1: k increments.
- RUN with k=N-1 (final slice):
  - Next edge loads y with the final value and sets out_valid=1 for exactly one cycle.
  - If start=0, next state is IDLE.
  - If start=1, this is a back-to-back accept: next state is RUN with k=0 and the accumulator cleared. No bubble cycle.
- start in RUN with k<N-1 is ignored. The sample in flight is unaffected. Upstream must not assert load here, because the caller owns that restriction.
- bit_en and busy are decoded combinationally from the state, so they are high exactly in RUN.

## Timing
- Reset values: state=IDLE, k=0, accumulator=0, y=0, out_valid=0, busy=0, bit_en=0.
- Reset has priority over start and over accumulation.
- Reset during RUN: the sample is abandoned, out_valid is not pulsed, and y returns to 0.
- Cycle numbering: start is sampled high at the edge ending cycle t. The shift registers load on that same edge.
- Cycles t+1..t+N are RUN. Cycle t+1+k carries slice k. bit_en is high in all N cycles, so the shift registers advance after each slice is consumed.
- out_valid is high in cycle t+N+1, with y valid in the same cycle.
- Latency: N+1 cycles from start to out_valid.
- Throughput: one sample every N cycles when start is asserted in each final RUN cycle.
- y and out_valid are registered outputs. bit_en and busy are state decodes and carry no combinational path from inputs.

## Test plan
All scenarios use N=4, W=8, so y is 12 bits.
- Reset, then idle 5 cycles -> y=0, out_valid=0, bit_en=0, busy=0 throughout.
- start pulse, psum=1 for all 4 slices -> bit_en high for exactly 4 cycles; out_valid single pulse 5 cycles after the start edge; y = 1+2+4−8 = −1 (0xFFF).
- Sign-bit extremes:
  - psum=−128 on slice 3 only, 0 on the other slices -> y=+1024.
  - psum=127 on slices 0–2 and −128 on slice 3 -> y = 127·7 + 1024 = 1913.
- Back-to-back: start held high continuously -> out_valid every 4 cycles; bit_en never drops; each y matches its own sample; no contribution carries over between samples.
- start pulsed in RUN with k=1 -> ignored; only one out_valid; y unchanged from the isolated-sample result.
- resetn low for one cycle while in RUN with k=2 -> no out_valid; y=0; IDLE next cycle; a following start produces a correct result.
